// File: rtl/hera_wb_ctrl.sv
// hera_wb_ctrl: register-file writeback controller.
// Merges three producers onto one registered write port:
//   - in-order load returns (highest priority)
//   - a two-beat multiply result (lo to mul_rd, then hi to R13)
//   - single-cycle ALU results (lowest priority)
// A small in-order queue remembers the destination of each outstanding load.
// That queue feeds a pending-register scoreboard and a source-operand hazard check.
module hera_wb_ctrl #(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [15:0] alu_data,
  output logic        alu_ready,
  input  logic        mul_valid,
  input  logic [3:0]  mul_rd,
  input  logic [15:0] mul_lo,
  input  logic [15:0] mul_hi,
  output logic        mul_ready,
  input  logic        ld_issue,
  input  logic [3:0]  ld_rd,
  output logic        ld_ready,
  input  logic        ld_rsp_valid,
  input  logic [15:0] ld_rsp_data,
  input  logic [3:0]  rsa,
  input  logic [3:0]  rsb,
  output logic        hazard,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [2:0]  ld_flags,
  output logic [15:0] pend,
  output logic        err
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;

  localparam logic [3:0] HI_REG = 4'd13;

  logic [3:0]    q_rd  [QDEPTH];
  logic [QDEPTH-1:0] q_vld;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  logic [1:0]  state;
  logic [3:0]  mul_rd_q;
  logic [15:0] mul_lo_q;
  logic [15:0] mul_hi_q;

  logic push;
  logic pop;
  logic grant;
  logic [3:0]  grant_addr;
  logic [15:0] grant_data;

  // The queue stays full to issue even while a response is popping this cycle.
  // A response at full therefore does not make room for a same-cycle issue.
  assign ld_ready  = (count < CW'(QDEPTH));
  assign push      = ld_issue & ld_ready;
  assign pop       = ld_rsp_valid & (count != '0);
  assign mul_ready = (state == ST_IDLE);
  assign alu_ready = alu_valid & ~pop & (state == ST_IDLE) & ~pend[alu_rd];

  // Scoreboard: one bit per register with a load still in flight.
  // r0 is never pending.
  always_comb begin
    pend = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_vld[i]) pend[q_rd[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign hazard = ((rsa != 4'd0) & pend[rsa]) | ((rsb != 4'd0) & pend[rsb]);

  // Fixed-priority write arbitration: load return, then multiply beat, then ALU.
  always_comb begin
    grant      = 1'b0;
    grant_addr = 4'd0;
    grant_data = 16'd0;
    if (pop) begin
      grant      = 1'b1;
      grant_addr = q_rd[rptr];
      grant_data = ld_rsp_data;
    end else if (state == ST_LO) begin
      grant      = 1'b1;
      grant_addr = mul_rd_q;
      grant_data = mul_lo_q;
    end else if (state == ST_HI) begin
      grant      = 1'b1;
      grant_addr = HI_REG;
      grant_data = mul_hi_q;
    end else if (alu_ready) begin
      grant      = 1'b1;
      grant_addr = alu_rd;
      grant_data = alu_data;
    end
  end

  // Load queue: in-order push/pop with per-slot valid bits for the scoreboard.
  // Push and pop never target the same slot.
  // That would need a push at full or a pop when empty, and neither is allowed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      q_vld <= '0;
      for (int i = 0; i < QDEPTH; i++) q_rd[i] <= 4'd0;
    end else begin
      if (push) begin
        q_rd[wptr]  <= ld_rd;
        q_vld[wptr] <= 1'b1;
        wptr        <= wptr + PW'(1);
      end
      if (pop) begin
        q_vld[rptr] <= 1'b0;
        rptr        <= rptr + PW'(1);
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Multiply sequencer: capture the pair, then emit lo and hi as separate writes.
  // It only advances on a cycle where no load return takes the port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      mul_rd_q <= 4'd0;
      mul_lo_q <= 16'd0;
      mul_hi_q <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: if (mul_valid) begin
          state    <= ST_LO;
          mul_rd_q <= mul_rd;
          mul_lo_q <= mul_lo;
          mul_hi_q <= mul_hi;
        end
        ST_LO:   if (!pop) state <= ST_HI;
        ST_HI:   if (!pop) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered write port and load flags.
  // Writes to r0 still present their address and data but leave the enable low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= 4'd0;
      wr_data  <= 16'd0;
      ld_flags <= 3'b000;
    end else begin
      wr_en <= grant & (grant_addr != 4'd0);
      if (grant) begin
        wr_addr <= grant_addr;
        wr_data <= grant_data;
      end
      if (pop) ld_flags <= {1'b1, ld_rsp_data[15], (ld_rsp_data == 16'h0000)};
      else     ld_flags[2] <= 1'b0;
    end
  end

  // Sticky error: a load return arrived with no load outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              err <= 1'b0;
    else if (ld_rsp_valid && count == '0)  err <= 1'b1;
  end

endmodule

// File: tb/tb_hera_wb_ctrl.sv
// tb_hera_wb_ctrl: directed testbench for hera_wb_ctrl.
// Every expected value below is worked out by hand from the block's behaviour.
module tb_hera_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mul_valid, ld_issue, ld_rsp_valid;
  logic [3:0]  alu_rd, mul_rd, ld_rd, rsa, rsb;
  logic [15:0] alu_data, mul_lo, mul_hi, ld_rsp_data;
  logic        alu_ready, mul_ready, ld_ready, hazard, wr_en, err;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data, pend;
  logic [2:0]  ld_flags;

  int total  = 0;
  int passed = 0;

  hera_wb_ctrl #(.QDEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_lo(mul_lo), .mul_hi(mul_hi),
    .mul_ready(mul_ready),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_ready(ld_ready),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
    .rsa(rsa), .rsb(rsb), .hazard(hazard),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_flags(ld_flags), .pend(pend), .err(err)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_write(input string tag, input logic [3:0] addr, input logic [15:0] data);
    check_output({tag, " wr_en"}, 32'(wr_en), 32'd1);
    check_output({tag, " wr_addr"}, 32'(wr_addr), 32'(addr));
    check_output({tag, " wr_data"}, 32'(wr_data), 32'(data));
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mul_valid = 0; mul_rd = 0; mul_lo = 0; mul_hi = 0;
    ld_issue = 0; ld_rd = 0; ld_rsp_valid = 0; ld_rsp_data = 0;
    rsa = 0; rsb = 0;
    #12;
    check_output("rst wr_en", 32'(wr_en), 32'd0);
    check_output("rst wr_addr", 32'(wr_addr), 32'd0);
    check_output("rst wr_data", 32'(wr_data), 32'd0);
    check_output("rst ld_flags", 32'(ld_flags), 32'd0);
    check_output("rst pend", 32'(pend), 32'd0);
    check_output("rst err", 32'(err), 32'd0);
    check_output("rst ld_ready", 32'(ld_ready), 32'd1);
    check_output("rst mul_ready", 32'(mul_ready), 32'd1);
    rst = 1'b1;
    tick();

    // Single load to r5 with a negative return value
    ld_issue = 1; ld_rd = 5; rsa = 5;
    tick();
    ld_issue = 0; #1;
    check_output("ld5 pend", 32'(pend), 32'h0020);
    check_output("ld5 hazard", 32'(hazard), 32'd1);
    tick(); tick();
    ld_rsp_valid = 1; ld_rsp_data = 16'h8000; #1;
    check_output("ld5 hazard before pop", 32'(hazard), 32'd1);
    tick();
    ld_rsp_valid = 0; #1;
    check_write("ld5", 4'd5, 16'h8000);
    check_output("ld5 flags", 32'(ld_flags), 32'h6);
    check_output("ld5 pend after", 32'(pend), 32'd0);
    check_output("ld5 hazard after", 32'(hazard), 32'd0);
    tick();
    check_output("ld5 idle wr_en", 32'(wr_en), 32'd0);
    check_output("ld5 flags valid drop", 32'(ld_flags[2]), 32'd0);
    rsa = 0;

    // Fill the queue, overflow issue, and a response at full
    for (int i = 1; i <= 4; i++) begin
      ld_issue = 1; ld_rd = 4'(i);
      tick();
    end
    check_output("full ld_ready", 32'(ld_ready), 32'd0);
    check_output("full pend", 32'(pend), 32'h001E);
    ld_rd = 9;
    tick();
    check_output("overflow pend", 32'(pend), 32'h001E);
    ld_rd = 10; ld_rsp_valid = 1; ld_rsp_data = 16'h1111;
    tick();
    ld_issue = 0;
    check_write("q1", 4'd1, 16'h1111);
    check_output("q after rsp+issue pend", 32'(pend), 32'h001C);
    check_output("q count3 ld_ready", 32'(ld_ready), 32'd1);
    ld_rsp_data = 16'h2222; tick(); check_write("q2", 4'd2, 16'h2222);
    ld_rsp_data = 16'h3333; tick(); check_write("q3", 4'd3, 16'h3333);
    ld_rsp_data = 16'h4444; tick(); check_write("q4", 4'd4, 16'h4444);
    ld_rsp_valid = 0;
    tick();
    check_output("q drained pend", 32'(pend), 32'd0);
    check_output("q drained wr_en", 32'(wr_en), 32'd0);
    check_output("q no err", 32'(err), 32'd0);

    // Multiply stalled one cycle by a load return in its LO cycle
    ld_issue = 1; ld_rd = 6;
    tick();
    ld_issue = 0;
    mul_valid = 1; mul_rd = 7; mul_lo = 16'h1234; mul_hi = 16'hABCD; #1;
    check_output("mul accept ready", 32'(mul_ready), 32'd1);
    tick();
    mul_valid = 0; ld_rsp_valid = 1; ld_rsp_data = 16'h5555; #1;
    check_output("mul LO ready", 32'(mul_ready), 32'd0);
    tick();
    ld_rsp_valid = 0;
    check_write("mul ld", 4'd6, 16'h5555);
    check_output("mul stall ready", 32'(mul_ready), 32'd0);
    tick();
    check_write("mul lo", 4'd7, 16'h1234);
    check_output("mul HI ready", 32'(mul_ready), 32'd0);
    tick();
    check_write("mul hi", 4'd13, 16'hABCD);
    check_output("mul done ready", 32'(mul_ready), 32'd1);
    tick();
    check_output("mul idle wr_en", 32'(wr_en), 32'd0);

    // ALU blocked by a pending load to its destination, then an r0 write
    ld_issue = 1; ld_rd = 4;
    tick();
    ld_issue = 0;
    alu_valid = 1; alu_rd = 4; alu_data = 16'h7777; #1;
    check_output("alu pend ready", 32'(alu_ready), 32'd0);
    tick();
    check_output("alu stall wr_en", 32'(wr_en), 32'd0);
    ld_rsp_valid = 1; ld_rsp_data = 16'h0000; #1;
    check_output("alu pop-cycle ready", 32'(alu_ready), 32'd0);
    tick();
    ld_rsp_valid = 0; #1;
    check_write("alu ld4", 4'd4, 16'h0000);
    check_output("alu ld4 flags", 32'(ld_flags), 32'h5);
    check_output("alu free ready", 32'(alu_ready), 32'd1);
    tick();
    check_write("alu r4", 4'd4, 16'h7777);
    alu_rd = 0; alu_data = 16'h9999; #1;
    check_output("alu r0 ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 0;
    check_output("alu r0 wr_en", 32'(wr_en), 32'd0);

    // Response with nothing outstanding raises a sticky error
    ld_rsp_valid = 1; ld_rsp_data = 16'hDEAD;
    tick();
    ld_rsp_valid = 0;
    check_output("err set", 32'(err), 32'd1);
    check_output("err no write", 32'(wr_en), 32'd0);
    tick(); tick();
    check_output("err sticky", 32'(err), 32'd1);

    // Reset during the HI beat with two loads outstanding
    ld_issue = 1; ld_rd = 2; tick();
    ld_rd = 3; tick();
    ld_issue = 0;
    mul_valid = 1; mul_rd = 8; mul_lo = 16'h0001; mul_hi = 16'h0002;
    tick();
    mul_valid = 0;
    tick();
    check_write("rst2 lo", 4'd8, 16'h0001);
    check_output("rst2 pend before", 32'(pend), 32'h000C);
    rst = 1'b0; #1;
    check_output("rst2 wr_en", 32'(wr_en), 32'd0);
    check_output("rst2 wr_addr", 32'(wr_addr), 32'd0);
    check_output("rst2 wr_data", 32'(wr_data), 32'd0);
    check_output("rst2 pend", 32'(pend), 32'd0);
    check_output("rst2 ld_ready", 32'(ld_ready), 32'd1);
    check_output("rst2 mul_ready", 32'(mul_ready), 32'd1);
    check_output("rst2 err", 32'(err), 32'd0);
    check_output("rst2 flags", 32'(ld_flags), 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("rst2 no R13 write", 32'(wr_en), 32'd0);
    end
    check_output("rst2 pend after", 32'(pend), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard time limit so a broken design cannot hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
